// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  typedef enum logic {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  localparam int unsigned PC_STEP          = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO holding {pc, instr} pairs; flush empties it in one cycle.
module sync_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     wr_en_i,
  input  logic [W-1:0]             wr_data_i,
  input  logic                     rd_en_i,
  output logic [W-1:0]             rd_data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_wr, do_rd;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;

  // A write into a full queue is legal when the head leaves in the same cycle.
  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || do_rd);

  assign rd_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !flush_i && !rst) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited request issue, ordered response queue,
// and redirect handling that drains stale in-flight responses.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DW       = 32,
  parameter int          DEPTH    = 4,
  parameter logic [DW-1:0] RESET_PC = DW'(DEFAULT_RESET_PC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect,
  input  logic [DW-1:0] redirect_target,
  output logic          imem_req_valid,
  output logic [DW-1:0] imem_req_addr,
  input  logic          imem_req_ready,
  input  logic          imem_rsp_valid,
  input  logic [DW-1:0] imem_rsp_data,
  output logic          instr_valid,
  output logic [DW-1:0] instr,
  output logic [DW-1:0] instr_pc,
  input  logic          instr_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [DW-1:0] fetch_pc_q, fetch_pc_d;
  logic [DW-1:0] oldest_pc_q, oldest_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] stale_q, stale_d;

  logic [CW-1:0]   q_count;
  logic            q_empty, q_full;
  logic [2*DW-1:0] q_head;
  logic [CW:0]     inflight;
  logic [CW:0]     stale_sum;
  logic [DW-1:0]   target_aligned;
  logic            accept, rsp_keep, deq;
  logic            unused_ok;

  assign unused_ok      = ^{redirect_target[1:0], q_full};
  assign target_aligned = {redirect_target[DW-1:2], 2'b00};

  // Credit: every outstanding request owns a queue slot, so the queue cannot overflow.
  assign inflight = {1'b0, outst_q} + {1'b0, q_count};

  assign imem_req_valid = !rst && (state_q == FETCH) && !redirect
                          && (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign rsp_keep    = !rst && (state_q == FETCH) && imem_rsp_valid && !redirect;
  assign instr_valid = !rst && !q_empty;
  assign deq         = instr_valid && instr_ready && !redirect;

  assign instr_pc = instr_valid ? q_head[2*DW-1:DW] : '0;
  assign instr    = instr_valid ? q_head[DW-1:0]    : '0;

  sync_fifo #(
    .W     (2*DW),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (redirect),
    .wr_en_i   (rsp_keep),
    .wr_data_i ({oldest_pc_q, imem_rsp_data}),
    .rd_en_i   (deq),
    .rd_data_o (q_head),
    .empty_o   (q_empty),
    .full_o    (q_full),
    .count_o   (q_count)
  );

  // Responses still owed at redirect time are stale; one arriving this cycle is already drained.
  always_comb begin
    stale_sum = {1'b0, stale_q} + {1'b0, outst_q};
    if (imem_rsp_valid && stale_sum != '0) stale_sum = stale_sum - (CW+1)'(1);
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    oldest_pc_d = oldest_pc_q;
    outst_d     = outst_q;
    stale_d     = stale_q;
    if (redirect) begin
      fetch_pc_d  = target_aligned;
      oldest_pc_d = target_aligned;
      outst_d     = '0;
      stale_d     = stale_sum[CW-1:0];
      state_d     = (stale_sum[CW-1:0] != '0) ? FLUSH : FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (accept)   fetch_pc_d  = fetch_pc_q + DW'(PC_STEP);
          if (rsp_keep) oldest_pc_d = oldest_pc_q + DW'(PC_STEP);
          outst_d = outst_q + CW'(accept) - CW'(rsp_keep);
        end
        FLUSH: begin
          if (stale_q == '0) begin
            state_d = FETCH;
          end else if (imem_rsp_valid) begin
            stale_d = stale_q - CW'(1);
            if (stale_q == CW'(1)) state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH;
      fetch_pc_q  <= RESET_PC;
      oldest_pc_q <= RESET_PC;
      outst_q     <= '0;
      stale_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      oldest_pc_q <= oldest_pc_d;
      outst_q     <= outst_d;
      stale_q     <= stale_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order, queue-based memory responder.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  logic        rsp_en;
  logic [31:0] mq[$];
  int          acc_cnt = 0;
  int          ncmp = 0;
  int          nfail = 0;
  int          a0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready)
  );

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  // Memory: captures accepted addresses, returns one per cycle in order when rsp_en.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back(imem_req_addr);
        acc_cnt++;
      end
      if (rsp_en && mq.size() > 0) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mdata(mq.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_target = '0;
    imem_req_ready = 1'b1; rsp_en = 1'b1; instr_ready = 1'b1;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    tick(); tick();

    // Streaming with latency-1 memory
    rst = 1'b0; #1;
    chk("s_req_valid0", imem_req_valid, 1);
    chk("s_addr0", imem_req_addr, 32'h0);
    tick();
    chk("s_addr1", imem_req_addr, 32'h4);
    chk("s_ivalid_early", instr_valid, 0);
    tick();
    chk("s_ivalid", instr_valid, 1);
    chk("s_pc0", instr_pc, 32'h0);
    chk("s_instr0", instr, mdata(32'h0));
    chk("s_addr2", imem_req_addr, 32'h8);
    tick();
    chk("s_pc1", instr_pc, 32'h4);
    chk("s_addr3", imem_req_addr, 32'hC);

    // Backpressure: credit limits to DEPTH requests
    rst = 1'b1; instr_ready = 1'b0; tick(); tick();
    rst = 1'b0; a0 = acc_cnt;
    repeat (8) tick();
    chk("bp_accepts", acc_cnt - a0, 4);
    chk("bp_req_valid", imem_req_valid, 0);
    chk("bp_ivalid", instr_valid, 1);
    chk("bp_head_pc", instr_pc, 32'h0);
    instr_ready = 1'b1; #1;
    chk("bp_full_req", imem_req_valid, 0);
    tick();
    chk("bp_resume_valid", imem_req_valid, 1);
    chk("bp_resume_addr", imem_req_addr, 32'h10);
    chk("bp_next_pc", instr_pc, 32'h4);

    // Redirect with two outstanding, drained in FLUSH
    rst = 1'b1; tick(); tick();
    rst = 1'b0; rsp_en = 1'b0;
    tick(); tick();
    imem_req_ready = 1'b0; redirect = 1'b1; redirect_target = 32'h100; #1;
    chk("rd_valid_drop", imem_req_valid, 0);
    tick();
    redirect = 1'b0; imem_req_ready = 1'b1; rsp_en = 1'b1; #1;
    chk("rd_queue_empty", instr_valid, 0);
    chk("rd_flush_noreq0", imem_req_valid, 0);
    tick();
    chk("rd_flush_noreq1", imem_req_valid, 0);
    tick();
    chk("rd_flush_noreq2", imem_req_valid, 0);
    tick();
    chk("rd_fetch_valid", imem_req_valid, 1);
    chk("rd_fetch_addr", imem_req_addr, 32'h100);
    chk("rd_no_ghost", instr_valid, 0);
    tick(); tick();
    chk("rd_first_valid", instr_valid, 1);
    chk("rd_first_pc", instr_pc, 32'h100);
    chk("rd_first_instr", instr, mdata(32'h100));

    // Redirect coinciding with a response and a dequeue
    redirect = 1'b1; redirect_target = 32'h200; #1;
    chk("co_valid_drop", imem_req_valid, 0);
    tick();
    redirect = 1'b0; #1;
    chk("co_empty", instr_valid, 0);
    chk("co_req_valid", imem_req_valid, 1);
    chk("co_addr", imem_req_addr, 32'h200);
    tick(); tick();
    chk("co_pc", instr_pc, 32'h200);

    // Unaligned target is word-aligned
    redirect = 1'b1; redirect_target = 32'h103; tick();
    redirect = 1'b0; #1;
    chk("al_req_valid", imem_req_valid, 1);
    chk("al_addr", imem_req_addr, 32'h100);
    tick(); tick();
    chk("al_pc", instr_pc, 32'h100);
    chk("al_instr", instr, mdata(32'h100));

    // PC wraps modulo 2^32
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFE; tick();
    redirect = 1'b0; #1;
    chk("wr_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    chk("wr_addr_wrap", imem_req_addr, 32'h0);
    tick();
    chk("wr_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wr_addr_next", imem_req_addr, 32'h4);

    // Reset during FLUSH with two stale responses
    rst = 1'b1; tick(); tick();
    rst = 1'b0; rsp_en = 1'b0;
    tick(); tick();
    imem_req_ready = 1'b0; redirect = 1'b1; redirect_target = 32'h40; tick();
    redirect = 1'b0; imem_req_ready = 1'b1; #1;
    chk("fr_in_flush", imem_req_valid, 0);
    rst = 1'b1; #1;
    chk("fr_rst_req", imem_req_valid, 0);
    chk("fr_rst_ivalid", instr_valid, 0);
    tick();
    chk("fr_rst_req2", imem_req_valid, 0);
    chk("fr_rst_instr", instr, 0);
    chk("fr_rst_pc", instr_pc, 0);
    rst = 1'b0; rsp_en = 1'b1; #1;
    chk("fr_req_valid", imem_req_valid, 1);
    chk("fr_addr", imem_req_addr, 32'h0);
    chk("fr_ivalid", instr_valid, 0);
    tick(); tick();
    chk("fr_first_pc_valid", instr_valid, 1);
    chk("fr_first_pc", instr_pc, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter DW, default 32, giving the data and address width.
REQ-002 The module SHALL have parameter DEPTH, default 4, giving the prefetch queue depth (power of two, at least 2).
REQ-003 The module SHALL have parameter RESET_PC, default 32'h0, giving the first fetch address.
REQ-004 clk  in  1  The single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  Reset, synchronous and active-high.
REQ-006 redirect  in  1  Taken branch or jump from decode/execute (the PCsrc-taken event).
REQ-007 redirect_target  in  DW  New fetch address, valid when redirect=1.
REQ-008 imem_req_valid  out  1  Instruction memory request valid.
REQ-009 imem_req_addr  out  DW  Request byte address.
REQ-010 imem_req_ready  in  1  The memory accepts the request this cycle.
REQ-011 imem_rsp_valid  in  1  Response valid; responses return in request order, latency of 1 cycle or more.
REQ-012 imem_rsp_data  in  DW  Response instruction word.
REQ-013 instr_valid  out  1  The queue head is valid.
REQ-014 instr  out  DW  The queue head instruction.
REQ-015 instr_pc  out  DW  The PC of the queue head.
REQ-016 instr_ready  in  1  The downstream stage consumes the head this cycle.

Function
REQ-017 FSM states SHALL be FETCH and FLUSH.
REQ-018 A request SHALL be accepted when imem_req_valid and imem_req_ready are both high; on acceptance, fetch_pc SHALL advance by 4 (wrapping modulo 2^DW) and outstanding SHALL increment.
REQ-019 imem_req_valid SHALL be high iff state is FETCH, redirect=0, and outstanding+count<DEPTH (credit rule; the queue can never overflow).
REQ-020 imem_req_addr SHALL equal fetch_pc; while valid is high and ready is low, the address SHALL remain stable, and valid SHALL drop only on redirect.
REQ-021 In FETCH, a response SHALL be written to the queue with its PC (tracked by a pc-of-oldest-outstanding counter) and outstanding SHALL decrement.
REQ-022 The queue head SHALL be visible on instr/instr_pc one cycle after its response arrives; there SHALL be no combinational bypass.
REQ-023 The head SHALL be dequeued when instr_valid and instr_ready are both high; instr_valid SHALL be low when the queue is empty.
REQ-024 Simultaneous enqueue and dequeue SHALL be supported, including when the queue is full and when it is empty-with-write.
REQ-025 On redirect in any state: next cycle the queue SHALL be empty, fetch_pc SHALL equal {redirect_target[DW-1:2],2'b00}, and a stale count SHALL be loaded with the outstanding requests not yet returned.
REQ-026 Redirect SHALL have priority over a same-cycle request, enqueue, and dequeue; a same-cycle response SHALL count as stale.
REQ-027 If stale>0 after a redirect, the state SHALL become FLUSH, else FETCH.
REQ-028 In FLUSH, each response SHALL be discarded and decrement stale; no requests SHALL issue; when stale reaches 0 the state SHALL return to FETCH.
REQ-029 A repeated redirect during FLUSH SHALL overwrite fetch_pc, leave the state as FLUSH, and reload stale accordingly.
REQ-030 Latency SHALL be: with the queue empty and memory latency L, instr_valid rises L+1 cycles after request acceptance.

Reset
REQ-031 While rst=1: state=FETCH, fetch_pc=RESET_PC, outstanding=0, stale=0, queue empty, imem_req_valid=0, instr_valid=0, instr=0, instr_pc=0.
REQ-032 Reset mid-operation SHALL abandon all in-flight requests; responses arriving after reset deasserts for pre-reset requests are the environment's responsibility (memory is reset together with this block).

Structure
REQ-033 Package fetch_pkg SHALL hold the fetch_state_t enum (FETCH, FLUSH), PC_STEP=4, and the default RESET_PC.
REQ-034 One sub-module, sync_fifo (width 2*DW, depth DEPTH, with a flush input), SHALL implement the queue.

Verification
REQ-035 Reset deasserts, memory ready always with latency 1, instr_ready=1 -> requests at 0x0, 0x4, 0x8 on consecutive cycles; instr_pc=0x0 valid 2 cycles after the first acceptance.
REQ-036 instr_ready=0, memory always ready -> exactly 4 requests (0x0 to 0xC), then imem_req_valid=0; after instr_ready=1, the next request is 0x10.
REQ-037 Two requests outstanding, redirect to 0x100 -> next cycle instr_valid=0; two responses are dropped in FLUSH; next request 0x100; first delivered instr_pc=0x100.
REQ-038 Redirect in the same cycle as a response and a dequeue -> the response is dropped, the queue is empty, fetch_pc=target.
REQ-039 redirect_target=0x103 -> first request address 0x100.
REQ-040 rst asserted during FLUSH with stale=2 -> next cycle state=FETCH, fetch_pc=RESET_PC, all outputs at reset values.
